// File: rtl/rv_writeback.sv
// rv_writeback: final pipeline stage. Selects the result source, aligns and
// extends load data, holds the pipeline while a load/store is outstanding,
// drives the register-file write port and keeps a one-entry bypass register.
module rv_writeback #(
  parameter int unsigned LSU_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        w_stall_i,
  output logic        w_stall_req_o,
  input  logic        x_valid_i,
  input  logic [2:0]  x_fun_i,
  input  logic        x_load_i,
  input  logic        x_store_i,
  input  logic [4:0]  x_rd_i,
  input  logic        x_rd_write_i,
  input  logic [1:0]  x_rd_source_i,
  input  logic [31:0] x_rd_value_i,
  input  logic [31:0] x_rd_shifter_i,
  input  logic [31:0] x_rd_multiply_i,
  input  logic [31:0] x_dm_addr_i,
  input  logic [31:0] dm_data_l_i,
  input  logic        dm_load_done_i,
  input  logic        dm_store_done_i,
  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_rd_value_o,
  output logic        rf_rd_write_o,
  output logic [4:0]  byp_rd_o,
  output logic [31:0] byp_value_o,
  output logic        byp_valid_o,
  output logic        bus_error_o
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned RW    = 5;
  localparam bit          TO_EN = (LSU_TIMEOUT != 0);
  localparam int unsigned CNT_W = (LSU_TIMEOUT > 1) ? $clog2(LSU_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LSU_TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_LOAD  = 2'd1,
    S_WAIT_STORE = 2'd2
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [RW-1:0]     cap_rd;
  logic [2:0]        cap_fun;
  logic [1:0]        cap_lane;
  logic              cap_wr;
  // done_q: the bundle still presented in W has already retired and must be
  // dropped rather than re-issued; pend_* carries a write deferred by w_stall_i.
  logic              done_q;
  logic              pend_wr;
  logic [RW-1:0]     pend_rd;
  logic [XLEN-1:0]   pend_val;
  logic              bus_error_q;
  logic [RW-1:0]     byp_rd_q;
  logic [XLEN-1:0]   byp_value_q;
  logic              byp_valid_q;

  logic              accept;
  logic              is_load;
  logic              is_store;
  logic              enter_load_wait;
  logic              enter_store_wait;
  logic              load_done_w;
  logic              store_done_w;
  logic              timeout;
  logic              wr_en;
  logic [RW-1:0]     wr_rd;
  logic [XLEN-1:0]   wr_val;
  logic [XLEN-1:0]   src_val;

  logic unused_addr_hi;
  assign unused_addr_hi = ^x_dm_addr_i[31:2];

  // Select and extend the addressed lane of a load word.
  function automatic logic [XLEN-1:0] load_align(input logic [2:0] fun,
                                                  input logic [1:0] lane,
                                                  input logic [XLEN-1:0] data);
    logic [7:0]  b;
    logic [15:0] h;
    logic [XLEN-1:0] r;
    case (lane)
      2'd0:    b = data[7:0];
      2'd1:    b = data[15:8];
      2'd2:    b = data[23:16];
      default: b = data[31:24];
    endcase
    h = lane[1] ? data[31:16] : data[15:0];
    case (fun)
      3'b000:  r = {{24{b[7]}}, b};
      3'b100:  r = {24'd0, b};
      3'b001:  r = {{16{h[15]}}, h};
      3'b101:  r = {16'd0, h};
      3'b010:  r = data;
      default: r = '0;
    endcase
    return r;
  endfunction

  // Issue/completion decode and combinational stall request.
  always_comb begin
    is_load          = x_load_i;
    is_store         = x_store_i & ~x_load_i;
    accept           = rst_n_i & x_valid_i & ~w_stall_i & (state == S_IDLE) & ~done_q;
    enter_load_wait  = accept & is_load & ~dm_load_done_i;
    enter_store_wait = accept & is_store & ~dm_store_done_i;
    load_done_w      = (state == S_WAIT_LOAD) & dm_load_done_i;
    store_done_w     = (state == S_WAIT_STORE) & dm_store_done_i;
    timeout          = TO_EN & (state != S_IDLE) & ~load_done_w & ~store_done_w &
                       (cnt >= CNT_LAST);
    w_stall_req_o    = (state != S_IDLE) | enter_load_wait | enter_store_wait;
    case (x_rd_source_i)
      2'b01:   src_val = x_rd_shifter_i;
      2'b10:   src_val = x_rd_multiply_i;
      default: src_val = x_rd_value_i;
    endcase
  end

  // Register-file write port: deferred write, wait-state load, or direct retire.
  always_comb begin
    wr_en  = 1'b0;
    wr_rd  = '0;
    wr_val = '0;
    if (state == S_IDLE && done_q) begin
      if (!w_stall_i && pend_wr) begin
        wr_en  = 1'b1;
        wr_rd  = pend_rd;
        wr_val = pend_val;
      end
    end else if (load_done_w && !w_stall_i) begin
      wr_en  = cap_wr & (cap_rd != '0);
      wr_rd  = cap_rd;
      wr_val = load_align(cap_fun, cap_lane, dm_data_l_i);
    end else if (accept && is_load && dm_load_done_i) begin
      wr_en  = x_rd_write_i & (x_rd_i != '0);
      wr_rd  = x_rd_i;
      wr_val = load_align(x_fun_i, x_dm_addr_i[1:0], dm_data_l_i);
    end else if (accept && !is_load && !is_store) begin
      wr_en  = x_rd_write_i & (x_rd_i != '0);
      wr_rd  = x_rd_i;
      wr_val = src_val;
    end
    rf_rd_write_o = wr_en;
    rf_rd_o       = wr_en ? wr_rd : '0;
    rf_rd_value_o = wr_en ? wr_val : '0;
  end

  // FSM, capture/pending registers, timeout counter and bypass register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= S_IDLE;
      cnt         <= '0;
      cap_rd      <= '0;
      cap_fun     <= '0;
      cap_lane    <= '0;
      cap_wr      <= 1'b0;
      done_q      <= 1'b0;
      pend_wr     <= 1'b0;
      pend_rd     <= '0;
      pend_val    <= '0;
      bus_error_q <= 1'b0;
      byp_rd_q    <= '0;
      byp_value_q <= '0;
      byp_valid_q <= 1'b0;
    end else begin
      bus_error_q <= timeout;
      if (wr_en) begin
        byp_rd_q    <= wr_rd;
        byp_value_q <= wr_val;
        byp_valid_q <= 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (done_q) begin
            if (!w_stall_i) begin
              done_q  <= 1'b0;
              pend_wr <= 1'b0;
            end
          end else if (enter_load_wait || enter_store_wait) begin
            state    <= enter_load_wait ? S_WAIT_LOAD : S_WAIT_STORE;
            cap_rd   <= x_rd_i;
            cap_fun  <= x_fun_i;
            cap_lane <= x_dm_addr_i[1:0];
            cap_wr   <= x_rd_write_i;
            cnt      <= CNT_W'(1);
          end
        end
        S_WAIT_LOAD, S_WAIT_STORE: begin
          if (load_done_w || store_done_w) begin
            state    <= S_IDLE;
            cnt      <= '0;
            done_q   <= 1'b1;
            pend_wr  <= load_done_w & w_stall_i & cap_wr & (cap_rd != '0);
            pend_rd  <= cap_rd;
            pend_val <= load_align(cap_fun, cap_lane, dm_data_l_i);
          end else if (timeout) begin
            state   <= S_IDLE;
            cnt     <= '0;
            done_q  <= 1'b1;
            pend_wr <= 1'b0;
          end else if (TO_EN) begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign byp_rd_o    = byp_rd_q;
  assign byp_value_o = byp_value_q;
  assign byp_valid_o = byp_valid_q;
  assign bus_error_o = bus_error_q;

endmodule

// File: tb/tb_rv_writeback.sv
// Directed bench for rv_writeback with LSU_TIMEOUT=8.
`timescale 1ns/1ps
module tb_rv_writeback;

  logic        clk_i = 1'b0;
  logic        rst_n_i;
  logic        w_stall_i;
  logic        w_stall_req_o;
  logic        x_valid_i;
  logic [2:0]  x_fun_i;
  logic        x_load_i;
  logic        x_store_i;
  logic [4:0]  x_rd_i;
  logic        x_rd_write_i;
  logic [1:0]  x_rd_source_i;
  logic [31:0] x_rd_value_i;
  logic [31:0] x_rd_shifter_i;
  logic [31:0] x_rd_multiply_i;
  logic [31:0] x_dm_addr_i;
  logic [31:0] dm_data_l_i;
  logic        dm_load_done_i;
  logic        dm_store_done_i;
  logic [4:0]  rf_rd_o;
  logic [31:0] rf_rd_value_o;
  logic        rf_rd_write_o;
  logic [4:0]  byp_rd_o;
  logic [31:0] byp_value_o;
  logic        byp_valid_o;
  logic        bus_error_o;

  int total = 0;
  int bad   = 0;

  rv_writeback #(.LSU_TIMEOUT(8)) dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .w_stall_i(w_stall_i),
    .w_stall_req_o(w_stall_req_o), .x_valid_i(x_valid_i), .x_fun_i(x_fun_i),
    .x_load_i(x_load_i), .x_store_i(x_store_i), .x_rd_i(x_rd_i),
    .x_rd_write_i(x_rd_write_i), .x_rd_source_i(x_rd_source_i),
    .x_rd_value_i(x_rd_value_i), .x_rd_shifter_i(x_rd_shifter_i),
    .x_rd_multiply_i(x_rd_multiply_i), .x_dm_addr_i(x_dm_addr_i),
    .dm_data_l_i(dm_data_l_i), .dm_load_done_i(dm_load_done_i),
    .dm_store_done_i(dm_store_done_i), .rf_rd_o(rf_rd_o),
    .rf_rd_value_o(rf_rd_value_o), .rf_rd_write_o(rf_rd_write_o),
    .byp_rd_o(byp_rd_o), .byp_value_o(byp_value_o), .byp_valid_o(byp_valid_o),
    .bus_error_o(bus_error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_in();
    x_valid_i = 0; x_fun_i = 0; x_load_i = 0; x_store_i = 0; x_rd_i = 0;
    x_rd_write_i = 0; x_rd_source_i = 0; x_rd_value_i = 0; x_rd_shifter_i = 0;
    x_rd_multiply_i = 0; x_dm_addr_i = 0; dm_data_l_i = 0;
    dm_load_done_i = 0; dm_store_done_i = 0;
  endtask

  task automatic load_op(input logic [2:0] fun, input logic [4:0] rd,
                         input logic [31:0] addr, input logic [31:0] data, input logic done);
    idle_in();
    x_valid_i = 1; x_load_i = 1; x_fun_i = fun; x_rd_i = rd; x_rd_write_i = 1;
    x_dm_addr_i = addr; dm_data_l_i = data; dm_load_done_i = done;
  endtask

  task automatic alu_op(input logic [1:0] src, input logic [4:0] rd);
    idle_in();
    x_valid_i = 1; x_rd_source_i = src; x_rd_i = rd; x_rd_write_i = 1;
    x_rd_value_i = 32'h0000_1234; x_rd_shifter_i = 32'hDEAD_0005;
    x_rd_multiply_i = 32'h0BAD_F00D;
  endtask

  int stalls, errs, wrs;
  logic prev;

  initial begin
    rst_n_i = 0; w_stall_i = 0; idle_in();
    #12;
    // reset state
    chk("rst_stall", w_stall_req_o, 0);
    chk("rst_rfw",   rf_rd_write_o, 0);
    chk("rst_bypv",  byp_valid_o, 0);
    chk("rst_berr",  bus_error_o, 0);
    rst_n_i = 1;
    step();

    // 1: lb lane 3, done in issue cycle
    load_op(3'b000, 5'd3, 32'h0000_1003, 32'h80FF_0000, 1); #1;
    chk("lb_wr",    rf_rd_write_o, 1);
    chk("lb_rd",    rf_rd_o, 3);
    chk("lb_val",   rf_rd_value_o, 32'hFFFF_FF80);
    chk("lb_stall", w_stall_req_o, 0);
    step(); idle_in(); #1;
    chk("lb_byp_rd",  byp_rd_o, 3);
    chk("lb_byp_val", byp_value_o, 32'hFFFF_FF80);
    chk("lb_byp_v",   byp_valid_o, 1);

    // extra alignment cases, all done in issue cycle
    step(); load_op(3'b001, 5'd4, 32'h0000_0000, 32'h0000_8001, 1); #1;
    chk("lh_val", rf_rd_value_o, 32'hFFFF_8001);
    step(); load_op(3'b100, 5'd4, 32'h0000_0001, 32'h0000_AB00, 1); #1;
    chk("lbu_val", rf_rd_value_o, 32'h0000_00AB);
    step(); load_op(3'b011, 5'd4, 32'h0000_0000, 32'hFFFF_FFFF, 1); #1;
    chk("bad_fun_wr",  rf_rd_write_o, 1);
    chk("bad_fun_val", rf_rd_value_o, 0);
    step(); load_op(3'b010, 5'd0, 32'h0000_0000, 32'h1111_1111, 1); #1;
    chk("ld_x0_wr", rf_rd_write_o, 0);
    step(); idle_in(); #1;
    chk("ld_x0_byp", byp_value_o, 0);

    // 2: lhu lane 2, done on third stalled cycle
    step(); load_op(3'b101, 5'd7, 32'h0000_2002, 32'h0, 0); #1;
    chk("lhu_c0_stall", w_stall_req_o, 1);
    chk("lhu_c0_wr",    rf_rd_write_o, 0);
    step(); #1;
    chk("lhu_c1_stall", w_stall_req_o, 1);
    chk("lhu_c1_wr",    rf_rd_write_o, 0);
    step(); dm_data_l_i = 32'h9ABC_1234; dm_load_done_i = 1; #1;
    chk("lhu_c2_stall", w_stall_req_o, 1);
    chk("lhu_c2_wr",    rf_rd_write_o, 1);
    chk("lhu_c2_rd",    rf_rd_o, 7);
    chk("lhu_c2_val",   rf_rd_value_o, 32'h0000_9ABC);
    step(); dm_load_done_i = 0; #1;
    chk("lhu_c3_stall", w_stall_req_o, 0);
    chk("lhu_c3_nowr",  rf_rd_write_o, 0);
    step(); idle_in(); #1;
    chk("lhu_byp", byp_value_o, 32'h0000_9ABC);

    // 3: store that never completes -> timeout after 8 stalled cycles
    idle_in(); x_valid_i = 1; x_store_i = 1; x_fun_i = 3'b010; x_rd_i = 5'd9;
    stalls = 0; errs = 0; wrs = 0;
    for (int c = 0; c < 12; c++) begin
      #1;
      if (w_stall_req_o) stalls++;
      if (bus_error_o)   errs++;
      if (rf_rd_write_o) wrs++;
      prev = w_stall_req_o;
      step();
      if (!prev) idle_in();
    end
    chk("to_stalls", stalls, 8);
    chk("to_berr",   errs, 1);
    chk("to_wr",     wrs, 0);
    chk("to_idle",   w_stall_req_o, 0);

    // 4: ALU to x0 suppressed, then shifter/multiply/source 11
    alu_op(2'b00, 5'd0); #1;
    chk("alu_x0_wr", rf_rd_write_o, 0);
    step(); idle_in(); #1;
    chk("alu_x0_byp_rd",  byp_rd_o, 7);
    chk("alu_x0_byp_val", byp_value_o, 32'h0000_9ABC);
    alu_op(2'b01, 5'd5); #1;
    chk("shf_val", rf_rd_value_o, 32'hDEAD_0005);
    step(); idle_in(); #1;
    chk("shf_byp_rd",  byp_rd_o, 5);
    chk("shf_byp_val", byp_value_o, 32'hDEAD_0005);
    chk("shf_byp_v",   byp_valid_o, 1);
    alu_op(2'b10, 5'd6); #1;
    chk("mul_val", rf_rd_value_o, 32'h0BAD_F00D);
    step(); alu_op(2'b11, 5'd6); #1;
    chk("src11_val", rf_rd_value_o, 32'h0000_1234);
    step();

    // 5: async reset while waiting for a load
    load_op(3'b010, 5'd8, 32'h0000_0100, 32'h0, 0);
    step(); #1;
    chk("rw_wait_stall", w_stall_req_o, 1);
    rst_n_i = 0; #1;
    chk("rw_stall", w_stall_req_o, 0);
    chk("rw_wr",    rf_rd_write_o, 0);
    chk("rw_bypv",  byp_valid_o, 0);
    chk("rw_byprd", byp_rd_o, 0);
    chk("rw_berr",  bus_error_o, 0);
    idle_in();
    step(); rst_n_i = 1;
    step(); dm_load_done_i = 1; dm_data_l_i = 32'h5555_5555; #1;
    chk("late_done_wr", rf_rd_write_o, 0);
    step(); idle_in(); #1;
    chk("late_done_byp", byp_valid_o, 0);

    // 6: load completes while globally stalled; single deferred write
    load_op(3'b010, 5'd9, 32'h0000_0100, 32'h0, 0); #1;
    chk("st_c0_stall", w_stall_req_o, 1);
    step(); w_stall_i = 1; dm_load_done_i = 1; dm_data_l_i = 32'hCAFE_F00D; #1;
    chk("st_c1_wr", rf_rd_write_o, 0);
    step(); dm_load_done_i = 0; dm_data_l_i = 0; #1;
    chk("st_c2_wr",    rf_rd_write_o, 0);
    chk("st_c2_stall", w_stall_req_o, 0);
    step(); #1;
    chk("st_c3_wr", rf_rd_write_o, 0);
    step(); w_stall_i = 0; #1;
    chk("st_c4_wr",  rf_rd_write_o, 1);
    chk("st_c4_rd",  rf_rd_o, 9);
    chk("st_c4_val", rf_rd_value_o, 32'hCAFE_F00D);
    step(); idle_in(); #1;
    chk("st_c5_wr",  rf_rd_write_o, 0);
    chk("st_c5_byp", byp_value_o, 32'hCAFE_F00D);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
